// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
// Owner tags identify which requester a pending read response belongs to.
package imem_pkg;

    localparam int unsigned ROM_SIZE   = 128;
    localparam int unsigned ROM_BIT    = 7;
    localparam int unsigned STARVE_MAX = 4;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    // A byte address is in range when its word index falls inside the memory.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return (addr >> 2) < depth;
    endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Saturating counter of consecutive denied loader cycles; at_max forces a grant.
module imem_starve_counter #(
    parameter  int unsigned MAX = 4,
    localparam int unsigned W   = $clog2(MAX + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max = (r_cnt == W'(MAX));
    assign o_at_max = w_at_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (IF fetch / program loader) for a single-port instruction RAM.
// Optional grant statistics outputs are built when IMEM_ARB_STATS_EN is defined.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ROM_SIZE   = imem_pkg::ROM_SIZE,
    parameter int unsigned ROM_BIT    = imem_pkg::ROM_BIT,
    parameter int unsigned STARVE_MAX = imem_pkg::STARVE_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_hold,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [31:0]        if_rdata,
    input  logic               ld_req,
    input  logic               ld_we,
    input  logic [31:0]        ld_addr,
    input  logic [31:0]        ld_wdata,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    output logic [31:0]        ld_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ROM_BIT-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
`ifdef IMEM_ARB_STATS_EN
    output logic [15:0]        stat_if_cnt,
    output logic [15:0]        stat_ld_cnt,
    output logic [15:0]        stat_starve_cnt,
`endif
    input  logic [31:0]        mem_rdata
);

    logic        w_if_gnt;
    logic        w_ld_gnt;
    logic        w_forced;
    logic        w_at_max;
    logic        w_if_in;
    logic        w_ld_in;
    logic [31:0] w_resp_data;

    owner_e      r_owner;
    logic        r_oor;
    logic [31:0] r_if_rdata;
    logic [31:0] r_ld_rdata;

    assign w_if_in  = addr_in_range(if_addr, ROM_SIZE);
    assign w_ld_in  = addr_in_range(ld_addr, ROM_SIZE);
    assign w_forced = ~cpu_hold & w_at_max & ld_req;

    // Grants are held low during reset so every output reads 0 while reset is asserted.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ld_gnt = 1'b0;
        if (reset) begin
            if (cpu_hold) begin
                w_ld_gnt = ld_req;
            end else if (w_forced) begin
                w_ld_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else begin
                w_ld_gnt = ld_req;
            end
        end
    end

    imem_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_inc    (ld_req & ~w_ld_gnt),
        .i_clr    (w_ld_gnt | ~ld_req),
        .o_at_max (w_at_max)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_gnt) begin
            mem_en   = w_if_in;
            mem_addr = if_addr[ROM_BIT+1:2];
        end else if (w_ld_gnt) begin
            mem_en    = w_ld_in;
            mem_we    = ld_we & w_ld_in;
            mem_addr  = ld_addr[ROM_BIT+1:2];
            mem_wdata = ld_wdata;
        end
    end

    assign if_gnt = w_if_gnt;
    assign ld_gnt = w_ld_gnt;

    // Response tracking: owner tag plus out-of-range flag for the read issued last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_NONE;
            r_oor      <= 1'b0;
            r_if_rdata <= NOP_WORD;
            r_ld_rdata <= NOP_WORD;
        end else begin
            if (w_if_gnt) begin
                r_owner <= OWN_IF;
                r_oor   <= ~w_if_in;
            end else if (w_ld_gnt && !ld_we) begin
                r_owner <= OWN_LD;
                r_oor   <= ~w_ld_in;
            end else begin
                r_owner <= OWN_NONE;
                r_oor   <= 1'b0;
            end
            if (r_owner == OWN_IF) begin
                r_if_rdata <= w_resp_data;
            end
            if (r_owner == OWN_LD) begin
                r_ld_rdata <= w_resp_data;
            end
        end
    end

    assign w_resp_data = r_oor ? NOP_WORD : mem_rdata;

    // rdata passes memory data through on the response cycle, then holds it.
    assign if_rvalid = (r_owner == OWN_IF);
    assign ld_rvalid = (r_owner == OWN_LD);
    assign if_rdata  = if_rvalid ? w_resp_data : r_if_rdata;
    assign ld_rdata  = ld_rvalid ? w_resp_data : r_ld_rdata;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] r_stat_if;
    logic [15:0] r_stat_ld;
    logic [15:0] r_stat_starve;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_if     <= '0;
            r_stat_ld     <= '0;
            r_stat_starve <= '0;
        end else begin
            if (w_if_gnt && (r_stat_if != '1)) begin
                r_stat_if <= r_stat_if + 16'd1;
            end
            if (w_ld_gnt && (r_stat_ld != '1)) begin
                r_stat_ld <= r_stat_ld + 16'd1;
            end
            if (w_forced && (r_stat_starve != '1)) begin
                r_stat_starve <= r_stat_starve + 16'd1;
            end
        end
    end

    assign stat_if_cnt     = r_stat_if;
    assign stat_ld_cnt     = r_stat_ld;
    assign stat_starve_cnt = r_stat_starve;
`endif

endmodule
